// File: rtl/fifo_ptr_pkg.sv
// fifo_ptr_pkg: side selectors and Gray/binary conversion helpers shared by the FIFO pointer logic.
package fifo_ptr_pkg;
  localparam int SIDE_WRITE = 0;
  localparam int SIDE_READ  = 1;
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction
endpackage

// File: rtl/gray_to_binary.sv
// gray_to_binary: combinational Gray-to-binary decoder, bit i is the XOR of Gray bits W-1 down to i.
module gray_to_binary #(
  parameter int W = 5
) (
  input  logic [W-1:0] gray,
  output logic [W-1:0] bin
);
  for (genvar i = 0; i < W; i++) begin : g_bit
    assign bin[i] = ^gray[W-1:i];
  end
endmodule

// File: rtl/fifo_gray_ptr_ctrl.sv
// fifo_gray_ptr_ctrl: one side of an async FIFO, binary/Gray pointer with full or empty flag and level.
// Define FIFO_ALMOST_FLAG_EN to add ALMOST_THRESH and the registered almost_flag output.
module fifo_gray_ptr_ctrl
  import fifo_ptr_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int SIDE = 0
`ifdef FIFO_ALMOST_FLAG_EN
  , parameter int ALMOST_THRESH = 2
`endif
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  inc_req,
  input  logic [ADDR_WIDTH:0]   sync_gray_ptr,
  output logic                  inc_ack,
  output logic [ADDR_WIDTH-1:0] bin_addr,
  output logic [ADDR_WIDTH:0]   gray_ptr,
  output logic                  flag,
  output logic [ADDR_WIDTH:0]   level
`ifdef FIFO_ALMOST_FLAG_EN
  , output logic                almost_flag
`endif
);
  localparam int PW = ADDR_WIDTH + 1;
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  logic [PW-1:0] bin_q, bin_next, gray_next, remote_bin, level_next, full_cmp;
  logic flag_next;
  gray_to_binary #(.W(PW)) u_g2b (.gray(sync_gray_ptr), .bin(remote_bin));
  assign inc_ack = inc_req & ~flag;
  assign bin_addr = bin_q[ADDR_WIDTH-1:0];
  // Full is when our pointer has lapped the remote one: top two Gray bits inverted, rest equal.
  assign full_cmp = {~sync_gray_ptr[PW-1:PW-2], sync_gray_ptr[PW-3:0]};
  always_comb begin
    bin_next = bin_q + PW'(inc_ack);
    gray_next = PW'(bin2gray(32'(bin_next)));
    flag_next = (SIDE == SIDE_WRITE) ? (gray_next == full_cmp) : (gray_next == sync_gray_ptr);
    level_next = (SIDE == SIDE_WRITE) ? bin_next - remote_bin : remote_bin - bin_next;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bin_q <= '0;
      gray_ptr <= '0;
      flag <= (SIDE == SIDE_READ);
      level <= '0;
    end else begin
      bin_q <= bin_next;
      gray_ptr <= gray_next;
      flag <= flag_next;
      level <= level_next;
    end
  end
`ifdef FIFO_ALMOST_FLAG_EN
  logic almost_next;
  assign almost_next = (SIDE == SIDE_WRITE) ? (level_next >= PW'(DEPTH - ALMOST_THRESH))
                                            : (level_next <= PW'(ALMOST_THRESH));
  always_ff @(posedge clk) begin
    if (!rst_n) almost_flag <= (SIDE == SIDE_READ);
    else almost_flag <= almost_next;
  end
`endif
endmodule

// File: tb/tb_fifo_gray_ptr_ctrl.sv
// tb_fifo_gray_ptr_ctrl: directed checks of a write-side and a read-side pointer controller, ADDR_WIDTH=3.
module tb_fifo_gray_ptr_ctrl;
  logic clk = 0;
  logic rst_n, rw, rr;
  logic [3:0] sw, sr;
  logic aw, ar, fw, fr;
  logic [2:0] baw, bar;
  logic [3:0] gw, gr, lw, lr;
`ifdef FIFO_ALMOST_FLAG_EN
  logic alw, alr;
`endif
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;

  fifo_gray_ptr_ctrl #(
    .ADDR_WIDTH(3), .SIDE(0)
`ifdef FIFO_ALMOST_FLAG_EN
    , .ALMOST_THRESH(2)
`endif
  ) uw (
    .clk(clk), .rst_n(rst_n), .inc_req(rw), .sync_gray_ptr(sw), .inc_ack(aw),
    .bin_addr(baw), .gray_ptr(gw), .flag(fw), .level(lw)
`ifdef FIFO_ALMOST_FLAG_EN
    , .almost_flag(alw)
`endif
  );

  fifo_gray_ptr_ctrl #(
    .ADDR_WIDTH(3), .SIDE(1)
`ifdef FIFO_ALMOST_FLAG_EN
    , .ALMOST_THRESH(2)
`endif
  ) ur (
    .clk(clk), .rst_n(rst_n), .inc_req(rr), .sync_gray_ptr(sr), .inc_ack(ar),
    .bin_addr(bar), .gray_ptr(gr), .flag(fr), .level(lr)
`ifdef FIFO_ALMOST_FLAG_EN
    , .almost_flag(alr)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] g(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  initial begin
    logic [3:0] exp_g [8];
    logic [3:0] b;
    exp_g = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100, 4'b1100};
    rst_n = 0; rw = 1; rr = 1; sw = 0; sr = 0;
    step(); step();
    chk("rst_w_addr", 32'(baw), 0);
    chk("rst_w_gray", 32'(gw), 0);
    chk("rst_w_level", 32'(lw), 0);
    chk("rst_w_full", 32'(fw), 0);
    chk("rst_r_addr", 32'(bar), 0);
    chk("rst_r_gray", 32'(gr), 0);
    chk("rst_r_level", 32'(lr), 0);
    chk("rst_r_empty", 32'(fr), 1);
`ifdef FIFO_ALMOST_FLAG_EN
    chk("rst_w_almost", 32'(alw), 0);
    chk("rst_r_almost", 32'(alr), 1);
`endif
    rst_n = 1; rr = 0; rw = 1;
    for (int k = 0; k < 8; k++) begin
      #1 chk("w_ack", 32'(aw), 1);
      step();
      chk("w_gray", 32'(gw), 32'(exp_g[k]));
      chk("w_level", 32'(lw), k + 1);
      chk("w_full", 32'(fw), (k == 7) ? 1 : 0);
`ifdef FIFO_ALMOST_FLAG_EN
      chk("w_almost", 32'(alw), (k + 1 >= 6) ? 1 : 0);
`endif
    end
    chk("w_ack_full", 32'(aw), 0);
    step();
    chk("w_hold_gray", 32'(gw), 32'b1100);
    chk("w_hold_addr", 32'(baw), 0);
    chk("w_hold_level", 32'(lw), 8);
    chk("w_hold_full", 32'(fw), 1);
    rw = 0; sw = 4'b0011;
    step();
    chk("w_remote2_level", 32'(lw), 6);
    chk("w_remote2_full", 32'(fw), 0);
`ifdef FIFO_ALMOST_FLAG_EN
    chk("w_remote2_almost", 32'(alw), 1);
`endif
    sw = 4'b0010;
    step();
    chk("w_remote3_level", 32'(lw), 5);
`ifdef FIFO_ALMOST_FLAG_EN
    chk("w_remote3_almost", 32'(alw), 0);
`endif
    sr = 4'b0011;
    step();
    chk("r_remote_level", 32'(lr), 2);
    chk("r_remote_empty", 32'(fr), 0);
    rr = 1;
    #1 chk("r_ack1", 32'(ar), 1);
    step();
    chk("r_addr1", 32'(bar), 1);
    chk("r_level1", 32'(lr), 1);
    chk("r_empty1", 32'(fr), 0);
    chk("r_ack2", 32'(ar), 1);
    step();
    chk("r_gray2", 32'(gr), 32'b0011);
    chk("r_level2", 32'(lr), 0);
    chk("r_empty2", 32'(fr), 1);
    chk("r_ack3", 32'(ar), 0);
    step();
    chk("r_hold_addr", 32'(bar), 2);
    chk("r_hold_gray", 32'(gr), 32'b0011);
    chk("r_hold_empty", 32'(fr), 1);
    rr = 0;
    b = 4'd8;
    sw = g(4'd4); rw = 0;
    step();
    chk("wrap_pre_level", 32'(lw), 4);
    rw = 1;
    for (int k = 0; k < 16; k++) begin
      sw = g(b + 4'd1 - 4'd4);
      #1 chk("wrap_ack", 32'(aw), 1);
      step();
      b = b + 4'd1;
      chk("wrap_addr", 32'(baw), 32'(b[2:0]));
      chk("wrap_gray", 32'(gw), 32'(g(b)));
      chk("wrap_level", 32'(lw), 4);
      chk("wrap_full", 32'(fw), 0);
    end
    step();
    chk("mid_level5", 32'(lw), 5);
    chk("mid_gray", 32'(gw), 32'(g(4'd9)));
    rst_n = 0; rw = 1;
    step();
    chk("mid_rst_level", 32'(lw), 0);
    chk("mid_rst_gray", 32'(gw), 0);
    chk("mid_rst_full", 32'(fw), 0);
    chk("mid_rst_r_empty", 32'(fr), 1);
    chk("mid_rst_r_gray", 32'(gr), 0);
    rst_n = 1; sw = 0;
    step();
    chk("resume_gray", 32'(gw), 32'b0001);
    chk("resume_level", 32'(lw), 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
